// File: rtl/debounce_multi.sv
// debounce_multi: N-channel push-button debouncer with one shared sample-tick
// divider, per-channel stability counters, press/release pulses and an
// optional hold-to-repeat pulse. Everything runs on the single system clock.
module debounce_multi #(
    parameter int N_CH        = 4,
    parameter int TICK_DIV    = 250000,
    parameter int STABLE_CNT  = 4,
    parameter int ACTIVE_LOW  = 0,
    parameter int REPEAT_DLY  = 0,
    parameter int REPEAT_RATE = 40
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] btn_in,
    output logic [N_CH-1:0] btn_level,
    output logic [N_CH-1:0] btn_press,
    output logic [N_CH-1:0] btn_release,
    output logic [N_CH-1:0] btn_repeat,
    output logic            sample_tick
);

    localparam int TW = $clog2(TICK_DIV);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam int CW = $clog2(STABLE_CNT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CNT - 1);

    logic [N_CH-1:0] in_pol;
    logic [N_CH-1:0] sync_meta;
    logic [N_CH-1:0] sync;
    logic [TW-1:0]   tick_cnt;

    // Normalise polarity so that 1 always means "button pushed" downstream.
    assign in_pol = btn_in ^ {N_CH{ACTIVE_LOW != 0}};

    // Two-flop synchroniser per channel for the asynchronous button inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= '0;
            sync      <= '0;
        end else begin
            sync_meta <= in_pol;
            sync      <= sync_meta;
        end
    end

    // Shared free-running divider; wraps at TICK_DIV-1 so the strobe period is exact.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
        end else if (sample_tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    assign sample_tick = (tick_cnt == TICK_LAST);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [CW-1:0] cnt;
        logic          level_q;
        logic          press_q;
        logic          release_q;
        logic          rep_q;
        logic          flip;

        // The debounced level flips on the tick that completes STABLE_CNT disagreeing samples.
        assign flip = sample_tick && (sync[i] != level_q) && (cnt == CNT_LAST);

        // Stability counter, debounced level and the edge pulses, all updated on the same edge.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt       <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                press_q   <= 1'b0;
                release_q <= 1'b0;
                if (sample_tick) begin
                    if (flip) begin
                        cnt       <= '0;
                        level_q   <= ~level_q;
                        press_q   <= ~level_q;
                        release_q <= level_q;
                    end else if (sync[i] == level_q) begin
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            end
        end

        if (REPEAT_DLY > 0) begin : g_rep
            localparam int HMAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
            localparam int HW   = $clog2(HMAX + 1);

            logic [HW-1:0] hcnt;
            logic [HW-1:0] hnext;
            logic [HW-1:0] target;
            logic          rep_phase;

            assign hnext  = hcnt + 1'b1;
            assign target = rep_phase ? HW'(REPEAT_RATE) : HW'(REPEAT_DLY);

            // Hold counter: first pulse after REPEAT_DLY ticks, then every REPEAT_RATE;
            // a release tick (or any tick not held) clears it so release always wins.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    hcnt      <= '0;
                    rep_phase <= 1'b0;
                    rep_q     <= 1'b0;
                end else begin
                    rep_q <= 1'b0;
                    if (sample_tick) begin
                        if (!level_q || flip) begin
                            hcnt      <= '0;
                            rep_phase <= 1'b0;
                        end else if (hnext == target) begin
                            hcnt      <= '0;
                            rep_phase <= 1'b1;
                            rep_q     <= 1'b1;
                        end else begin
                            hcnt <= hnext;
                        end
                    end
                end
            end
        end else begin : g_norep
            assign rep_q = 1'b0;
        end

        assign btn_level[i]   = level_q;
        assign btn_press[i]   = press_q;
        assign btn_release[i] = release_q;
        assign btn_repeat[i]  = rep_q;
    end

endmodule

// File: doc/debounce_multi.md
Name: debounce_multi

Overview:
- Parametrised N-channel push-button debouncer: a successor to the single-channel slow-clock debouncer.
- Each channel has its own stability counter, a debounced level output, one-clock press and release pulses, and an optional hold-to-repeat pulse.
- All channels share one sample-tick divider on the system clock. No derived clocks are used.
- Sits between board push-buttons and the game/motion control logic.

Parameters:
N_CH, 4, number of independent button channels (>=1)
TICK_DIV, 250000, clk cycles per sample tick (>=2); 250000 = 2.5 ms at 100 MHz
STABLE_CNT, 4, consecutive differing samples needed to flip the debounced state (>=1)
ACTIVE_LOW, 0, 1 = raw inputs inverted before synchronisation
REPEAT_DLY, 0, ticks from press to first repeat pulse; 0 disables repeat
REPEAT_RATE, 40, ticks between later repeat pulses (>=1; ignored when REPEAT_DLY=0)

Ports:
clk  in  1  system clock, 100 MHz
rst_n  in  1  asynchronous active-low reset
btn_in  in  N_CH  raw asynchronous button inputs
btn_level  out  N_CH  debounced state, registered
btn_press  out  N_CH  one-clk pulse on debounced 0->1
btn_release  out  N_CH  one-clk pulse on debounced 1->0
btn_repeat  out  N_CH  one-clk auto-repeat pulse while held
sample_tick  out  1  one-clk shared sample strobe (for test/reuse)

Behaviour:
- Reset (rst_n=0, async assert):
  - All outputs, synchroniser flops, the tick counter, and all per-channel counters go to 0.
  - No pulse may appear during reset or on the first cycle after release.
- Input path:
  - in_i = btn_in[i] XOR ACTIVE_LOW.
  - Two-flop synchroniser per channel on clk gives sync[i].
- Tick generator:
  - Counter runs 0..TICK_DIV-1 and wraps to 0.
  - sample_tick=1 for exactly the one cycle where the counter equals TICK_DIV-1. Period is exactly TICK_DIV clks.
  - First tick occurs TICK_DIV cycles after reset release.
- Stability counter (per channel, width $clog2(STABLE_CNT+1)), evaluated only on tick cycles:
  - If sync != btn_level: cnt increments.
  - If the increment would reach STABLE_CNT: btn_level toggles and cnt is cleared.
  - If sync == btn_level: cnt is cleared. Any single agreeing sample restarts the count.
  - STABLE_CNT=1: level follows sync on every tick.
- Pulses:
  - btn_press and btn_release are registered at the same edge as the btn_level update. They are high for exactly one clk and never overlap on one channel.
  - Latency from a clean input edge: 2 clk (sync) plus the wait to the next tick, plus (STABLE_CNT-1) further ticks, plus 1 clk (register).
- Repeat (only when REPEAT_DLY>0; otherwise btn_repeat is held at 0):
  - Hold counter hcnt is cleared on the press edge.
  - On each later tick with btn_level=1, hcnt increments.
  - First btn_repeat fires on the REPEAT_DLY-th tick after the press tick.
  - Subsequent pulses fire every REPEAT_RATE ticks.
  - On release, hcnt clears and no repeat pulse fires.
  - A repeat and a release on the same tick cannot both occur: release wins.
  - Counter width covers max(REPEAT_DLY, REPEAT_RATE) with no wrap.
- Channels are fully independent. Simultaneous events on different channels all appear in the same cycle.
- Reset mid-count discards all partial counts.
  - An input still held high after reset release produces a fresh press after the full STABLE_CNT ticks.

Test Plan:
(All scenarios use N_CH=2, TICK_DIV=4, STABLE_CNT=3, REPEAT_DLY=5, REPEAT_RATE=2, ACTIVE_LOW=0.)
- Clean press on ch0, held -> btn_level[0] rises one clk after the 3rd tick that samples 1. btn_press[0] is high for that single cycle. ch1 outputs stay 0.
- Bounce on ch0 (high for 2 ticks, low for 1 tick, then high steady) -> no pulse at the glitch. Press occurs only after 3 consecutive high ticks.
- Hold ch0 for 12 ticks after press -> btn_repeat[0] pulses at ticks +5, +7, +9, +11 after the press tick. Each pulse lasts one clk.
- Release ch0 after the repeat sequence -> btn_release[0] fires after 3 low ticks. No further btn_repeat. btn_level[0]=0.
- Press ch0 and ch1 on the same clk -> btn_press=2'b11 in one cycle. Release ch1 only -> btn_release=2'b10.
- Assert rst_n=0 after 2 high ticks on ch0, release reset with input still high -> all outputs 0 through reset. Press appears 3 full ticks after the first post-reset tick. ACTIVE_LOW=1 rerun with inverted stimulus gives identical output timing.
